// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bitwise logic unit among four requesters.
// One operation is in flight at a time; the result is held until the consumer accepts it.
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [11:0]        op,
    input  logic [4*WIDTH-1:0] a,
    input  logic [4*WIDTH-1:0] b,
    output logic [3:0]         gnt,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state;
    state_t             state_next;
    logic [1:0]         ptr;
    logic [1:0]         win;
    logic [1:0]         idx;
    logic [1:0]         lat_id;
    logic [2:0]         lat_op;
    logic [WIDTH-1:0]   lat_a;
    logic [WIDTH-1:0]   lat_b;
    logic [WIDTH-1:0]   result;

    // Scan from the highest offset down so the requester closest to ptr wins last.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result = '0;
        case (lat_op)
            3'd0:    result = lat_a & lat_b;
            3'd1:    result = lat_a | lat_b;
            3'd2:    result = ~lat_a;
            3'd3:    result = ~(lat_a & lat_b);
            3'd4:    result = ~(lat_a | lat_b);
            3'd5:    result = lat_a ^ lat_b;
            3'd6:    result = ~(lat_a ^ lat_b);
            default: result = lat_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured at the arbitration edge so requesters may move on after grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            op_count  <= '0;
            ptr       <= '0;
            lat_id    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= 4'b0001 << win;
                        lat_id <= win;
                        lat_op <= op[3*win +: 3];
                        lat_a  <= a[WIDTH*win +: WIDTH];
                        lat_b  <= b[WIDTH*win +: WIDTH];
                        ptr    <= win + 2'd1;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    rsp_data  <= result;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_logic_unit_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req;
    logic [11:0]        op;
    logic [4*WIDTH-1:0] a;
    logic [4*WIDTH-1:0] b;
    logic [3:0]         gnt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               busy;
    logic [CNT_W-1:0]   op_count;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int model_count = 0;

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'hA5};

    logic_unit_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Rotating-priority pick: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return ~x;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return x ^ y;
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic checkReset();
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_valid", 32'(rsp_valid), 0);
        checkOutput("rst_id", 32'(rsp_id), 0);
        checkOutput("rst_data", 32'(rsp_data), 0);
        checkOutput("rst_count", 32'(op_count), 0);
        checkOutput("rst_busy", 32'(busy), 0);
    endtask

    // One arbitration cycle starting and ending at a falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [11:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input int stall, output logic [7:0] data_seen,
                                 output int id_seen);
        int w;
        logic [7:0] exp_d;
        req = r; op = o; a = av; b = bv;
        rsp_ready = 1'($urandom_range(0, 1));
        data_seen = '0;
        id_seen = -1;
        if (r == 4'b0000) begin
            @(posedge clk); @(negedge clk);
            checkOutput("idle_gnt", 32'(gnt), 0);
            checkOutput("idle_busy", 32'(busy), 0);
            checkOutput("idle_count", 32'(op_count), 32'(model_count));
            return;
        end
        w = model_pick(r);
        model_ptr = (w + 1) % 4;
        exp_d = model_op(o[3*w +: 3], av[8*w +: 8], bv[8*w +: 8]);
        @(posedge clk); @(negedge clk);
        checkOutput("gnt", 32'(gnt), 32'(1) << w);
        checkOutput("exec_busy", 32'(busy), 1);
        checkOutput("exec_valid", 32'(rsp_valid), 0);
        req = 4'($urandom); op = 12'($urandom); a = $urandom; b = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        checkOutput("gnt_pulse", 32'(gnt), 0);
        checkOutput("rsp_valid", 32'(rsp_valid), 1);
        checkOutput("rsp_id", 32'(rsp_id), 32'(w));
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_d));
        data_seen = rsp_data;
        id_seen = int'(rsp_id);
        rsp_ready = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            req = 4'($urandom); op = 12'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); @(negedge clk);
            checkOutput("hold_valid", 32'(rsp_valid), 1);
            checkOutput("hold_id", 32'(rsp_id), 32'(w));
            checkOutput("hold_data", 32'(rsp_data), 32'(exp_d));
            checkOutput("hold_gnt", 32'(gnt), 0);
            checkOutput("hold_busy", 32'(busy), 1);
            rsp_ready = (i == stall - 1);
        end
        @(posedge clk); @(negedge clk);
        model_count = (model_count + 1) % (1 << CNT_W);
        checkOutput("done_valid", 32'(rsp_valid), 0);
        checkOutput("done_busy", 32'(busy), 0);
        checkOutput("done_count", 32'(op_count), 32'(model_count));
        req = 4'b0000;
    endtask

    initial begin
        logic [7:0] d;
        int id;
        rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b0;
        #1;
        checkReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Round robin with every requester asking.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 12'($urandom), $urandom, $urandom, 0, d, id);
            checkOutput("rr_order", 32'(id), 32'(i % 4));
        end
        checkOutput("rr_count", 32'(op_count), 8);

        // Reset in the middle of the run with nothing requested.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset();
        model_ptr = 0; model_count = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(4'b0000, '0, '0, '0, 0, d, id);

        applyStimulus(4'b0100, 12'(5) << 6, 32'hF0 << 16, 32'h3C << 16, 0, d, id);
        checkOutput("single_data", 32'(d), 32'hCC);
        checkOutput("single_id", 32'(id), 2);
        checkOutput("single_count", 32'(op_count), 1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0001, 12'(i), 32'hA5, 32'h0F, 0, d, id);
            checkOutput("sweep", 32'(d), 32'(sweep_exp[i]));
        end

        applyStimulus(4'b0011, 12'($urandom), $urandom, $urandom, 10, d, id);
        applyStimulus(4'b0011, 12'($urandom), $urandom, $urandom, 0, d, id);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 12'($urandom), $urandom, $urandom,
                          $urandom_range(0, 3), d, id);
        end

        // Reset while an operation is executing: no response may follow.
        req = 4'b0100; op = 12'($urandom); a = $urandom; b = $urandom;
        @(posedge clk); @(negedge clk);
        checkOutput("midop_gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        #1;
        checkReset();
        model_ptr = 0; model_count = 0;
        @(negedge clk);
        rst = 1'b0; req = 4'b0000; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            checkOutput("midop_novalid", 32'(rsp_valid), 0);
            checkOutput("midop_count", 32'(op_count), 0);
        end
        applyStimulus(4'b1001, 12'($urandom), $urandom, $urandom, 1, d, id);
        checkOutput("midop_ptr", 32'(id), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
